// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer: holds the PC, fetches one word at a time over a
// variable-latency request/response port and computes the next PC on retire.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic [1:0]  pc_sel,
  input  logic [1:0]  is_jump,
  input  logic        br_cond,
  input  logic [31:0] jr_target,
  output logic        fetch_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [31:0]        pc_inc;
  logic signed [31:0] br_off;
  logic [31:0]        next_pc;

  assign pc_inc = pc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jumps outrank branches; reserved encodings fall through to sequential.
  always_comb begin
    next_pc = pc_inc;
    if (is_jump == 2'b01) begin
      next_pc = {pc_inc[31:28], instr_q[25:0], 2'b00};
    end else if (is_jump == 2'b10) begin
      next_pc = jr_target;
    end else if (pc_sel == 2'b01 && br_cond) begin
      next_pc = pc_inc + $unsigned(br_off);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_WAIT;
        req_d   = 1'b1;
        addr_d  = pc_q;
        cnt_d   = 8'd0;
      end
      S_WAIT: begin
        if (im_rvalid) begin
          instr_d = im_rdata;
          req_d   = 1'b0;
          vld_d   = 1'b1;
          state_d = S_HOLD;
        end else if (cnt_q == TMO_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          vld_d = 1'b0;
          if (next_pc[1:0] != 2'b00) begin
            // Misaligned target: keep the faulting PC visible for debug.
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            pc_d    = next_pc;
            addr_d  = next_pc;
            req_d   = 1'b1;
            cnt_d   = 8'd0;
            state_d = S_WAIT;
          end
        end
      end
      S_ERR: begin
        req_d = 1'b0;
        vld_d = 1'b0;
        err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      instr_q <= 32'd0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign im_req      = req_q;
  assign im_addr     = addr_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign func        = instr_q[5:0];
  assign pc          = pc_q;
  assign pc_plus4    = pc_inc;
  assign instr_valid = vld_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: bench drives the memory response port by hand.
module tb_ifetch_unit;

  logic        clk;
  logic        rstn;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  pc_sel;
  logic [1:0]  is_jump;
  logic        br_cond;
  logic [31:0] jr_target;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rstn(rstn), .im_req(im_req), .im_addr(im_addr),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata), .instr(instr), .opcode(opcode),
    .func(func), .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_sel(pc_sel), .is_jump(is_jump),
    .br_cond(br_cond), .jr_target(jr_target), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    im_rvalid = 1'b0; im_rdata = '0; instr_ready = 1'b0;
    pc_sel = 2'b00; is_jump = 2'b00; br_cond = 1'b0; jr_target = '0;
  endtask

  // Leaves the DUT in its IDLE cycle, at a negedge.
  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (im_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic give(input logic [31:0] d);
    im_rvalid = 1'b1;
    im_rdata  = d;
    @(negedge clk);
    im_rvalid = 1'b0;
    im_rdata  = '0;
  endtask

  task automatic retire(input logic [1:0] sel, input logic [1:0] jmp,
                        input logic br, input logic [31:0] jr);
    pc_sel = sel; is_jump = jmp; br_cond = br; jr_target = jr;
    instr_ready = 1'b1;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", im_req); end
    checks++; if (im_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", im_addr); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b want 0", instr_valid); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", fetch_err); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc); end
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", im_req); end
    checks++; if (im_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 0", im_addr); end
    give(32'h8C41_002A);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL first_vld: got %b want 1", instr_valid); end
    checks++; if (instr !== 32'h8C41_002A) begin errors++; $display("FAIL first_instr: got %h want 8c41002a", instr); end
    checks++; if (opcode !== 6'h23) begin errors++; $display("FAIL opcode: got %h want 23", opcode); end
    checks++; if (func !== 6'h2A) begin errors++; $display("FAIL func: got %h want 2a", func); end
    checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL pc_plus4: got %h want 4", pc_plus4); end
    checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL req_drop: got %b want 0", im_req); end
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = 32'(i * 4);
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL seq_req_timeout: got none want req"); end
      checks++; if (im_addr !== a) begin errors++; $display("FAIL seq_addr: got %h want %h", im_addr, a); end
      give(32'h0000_0020 + 32'(i));
      checks++; if (pc !== a) begin errors++; $display("FAIL seq_pc: got %h want %h", pc, a); end
      // Stray response and idle cycles while holding must not disturb outputs.
      im_rvalid = 1'b1; im_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      im_rvalid = 1'b0; im_rdata = '0;
      @(negedge clk);
      checks++; if (instr !== 32'h0000_0020 + 32'(i)) begin errors++; $display("FAIL hold_instr: got %h want %h", instr, 32'h20 + 32'(i)); end
      checks++; if (instr_valid !== 1'b1 || im_req !== 1'b0) begin errors++; $display("FAIL hold_ctl: got vld=%b req=%b want vld=1 req=0", instr_valid, im_req); end
      retire(2'b00, 2'b00, 1'b0, 32'h0);
      checks++; if (im_req !== 1'b1 || im_addr !== a + 32'd4) begin errors++; $display("FAIL seq_next: got req=%b addr=%h want req=1 addr=%h", im_req, im_addr, a + 32'd4); end
    end
  endtask

  task automatic test_branch();
    bit ok;
    do_reset();
    wait_req(ok); give(32'h0800_0004); retire(2'b00, 2'b01, 1'b0, 32'h0);
    checks++; if (im_addr !== 32'h10) begin errors++; $display("FAIL j_to_10: got %h want 10", im_addr); end
    wait_req(ok); give(32'h1022_FFFC); retire(2'b01, 2'b00, 1'b1, 32'h0);
    checks++; if (im_addr !== 32'h4 || pc !== 32'h4) begin errors++; $display("FAIL br_taken: got addr=%h pc=%h want 4", im_addr, pc); end
    wait_req(ok); give(32'h0800_0004); retire(2'b00, 2'b01, 1'b0, 32'h0);
    wait_req(ok); give(32'h1022_FFFC); retire(2'b01, 2'b00, 1'b0, 32'h0);
    checks++; if (im_addr !== 32'h14) begin errors++; $display("FAIL br_not_taken: got %h want 14", im_addr); end
    wait_req(ok); give(32'h1022_FFFC); retire(2'b10, 2'b00, 1'b1, 32'h0);
    checks++; if (im_addr !== 32'h18) begin errors++; $display("FAIL pc_sel_10: got %h want 18", im_addr); end
  endtask

  task automatic test_jump();
    bit ok;
    do_reset();
    wait_req(ok); give(32'h0); retire(2'b00, 2'b10, 1'b0, 32'h3000_0020);
    checks++; if (im_addr !== 32'h3000_0020 || pc !== 32'h3000_0020) begin errors++; $display("FAIL jr: got addr=%h pc=%h want 30000020", im_addr, pc); end
    wait_req(ok); give(32'h0800_0100); retire(2'b01, 2'b01, 1'b1, 32'h0);
    checks++; if (im_addr !== 32'h3000_0400) begin errors++; $display("FAIL j_priority: got %h want 30000400", im_addr); end
    wait_req(ok); give(32'h0800_0100); retire(2'b00, 2'b11, 1'b0, 32'h0);
    checks++; if (im_addr !== 32'h3000_0404) begin errors++; $display("FAIL jmp_reserved: got %h want 30000404", im_addr); end
    wait_req(ok); give(32'h0); retire(2'b00, 2'b10, 1'b0, 32'hFFFF_FFFC);
    wait_req(ok); give(32'h0); retire(2'b00, 2'b00, 1'b0, 32'h0);
    checks++; if (im_addr !== 32'h0 || im_req !== 1'b1 || fetch_err !== 1'b0) begin errors++; $display("FAIL wrap: got addr=%h req=%b err=%b want 0/1/0", im_addr, im_req, fetch_err); end
  endtask

  task automatic test_fault();
    bit ok;
    do_reset();
    wait_req(ok); give(32'h0); retire(2'b00, 2'b10, 1'b0, 32'h0000_0102);
    checks++; if (fetch_err !== 1'b1 || im_req !== 1'b0) begin errors++; $display("FAIL misalign: got err=%b req=%b want 1/0", fetch_err, im_req); end
    checks++; if (instr_valid !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL misalign_state: got vld=%b pc=%h want 0/0", instr_valid, pc); end
    give(32'h0000_1234);
    retire(2'b00, 2'b00, 1'b0, 32'h0);
    checks++; if (instr_valid !== 1'b0 || fetch_err !== 1'b1 || im_req !== 1'b0) begin errors++; $display("FAIL err_sticky: got vld=%b err=%b req=%b want 0/1/0", instr_valid, fetch_err, im_req); end
    do_reset();
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", fetch_err); end
    wait_req(ok);
    repeat (254) @(negedge clk);
    checks++; if (fetch_err !== 1'b0 || im_req !== 1'b1) begin errors++; $display("FAIL tmo_early: got err=%b req=%b want 0/1", fetch_err, im_req); end
    @(negedge clk);
    checks++; if (fetch_err !== 1'b1 || im_req !== 1'b0) begin errors++; $display("FAIL tmo: got err=%b req=%b want 1/0", fetch_err, im_req); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    do_reset();
    wait_req(ok); give(32'h0); retire(2'b00, 2'b00, 1'b0, 32'h0);
    checks++; if (im_addr !== 32'h4) begin errors++; $display("FAIL pre_rst_addr: got %h want 4", im_addr); end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if (im_req !== 1'b0 || pc !== 32'h0 || im_addr !== 32'h0) begin errors++; $display("FAIL mid_rst: got req=%b pc=%h addr=%h want 0/0/0", im_req, pc, im_addr); end
    @(negedge clk);
    rstn = 1'b1;
    im_rvalid = 1'b1; im_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    im_rvalid = 1'b0; im_rdata = '0;
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL late_rvalid: got vld=%b instr=%h want 0/0", instr_valid, instr); end
    checks++; if (im_req !== 1'b1 || im_addr !== 32'h0) begin errors++; $display("FAIL restart: got req=%b addr=%h want 1/0", im_req, im_addr); end
    give(32'h0000_0001);
    checks++; if (instr_valid !== 1'b1 || instr !== 32'h1) begin errors++; $display("FAIL post_rst_fetch: got vld=%b instr=%h want 1/1", instr_valid, instr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_fault();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
